// File: rtl/regfile_scan_port_pkg.sv
// Purpose : shared FSM encoding and sizing helper for the register-file scan bridge.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package regfile_scan_port_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Scan cycles needed to move one register through the NSHIFT-wide port.
   function automatic int byte_cycles(input int reg_bits, input int nshift);
      return reg_bits / nshift;
   endfunction

endpackage

// File: rtl/regfile_scan_port.sv
// Purpose : parallel read/write (narrow or register-pair) bridge onto the bit-serial regfile scan port.
// Latency : accept -> rsp_valid = REG_BITS/NSHIFT+1 cycles narrow, 2*REG_BITS/NSHIFT+1 wide.
// Backpr. : one request in flight; req_ready is low in SCAN and DONE, next accept the cycle after DONE.
//
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   req_valid/req_ready                request handshake
//   req_write, req_wide, req_index, req_wdata   request fields (wide = index, then index^1)
//   rsp_valid, rsp_rdata               completion pulse and result (held until next accept)
//   reg_index, do_scan, scan_in, bit_index      drive the regfile scan port
//   scan_out                           data returned by the regfile scan port
//
// Build option: define REGFILE_SCAN_PORT_XCHG_EN to make writes return the previous
// register contents (atomic exchange); otherwise writes return zero.
module regfile_scan_port
   import regfile_scan_port_pkg::*;
#(
   parameter int LOG2_NR  = 4,
   parameter int REG_BITS = 8,
   parameter int NSHIFT   = 2
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  req_valid,
   output logic                                  req_ready,
   input  logic                                  req_write,
   input  logic                                  req_wide,
   input  logic [LOG2_NR-1:0]                    req_index,
   input  logic [2*REG_BITS-1:0]                 req_wdata,
   output logic                                  rsp_valid,
   output logic [2*REG_BITS-1:0]                 rsp_rdata,
   output logic [LOG2_NR-1:0]                    reg_index,
   output logic                                  do_scan,
   output logic [NSHIFT-1:0]                     scan_in,
   input  logic [NSHIFT-1:0]                     scan_out,
   output logic [$clog2(2*REG_BITS/NSHIFT)-1:0]  bit_index
);

   localparam int W           = 2 * REG_BITS;
   localparam int BYTE_CYCLES = byte_cycles(REG_BITS, NSHIFT);
   localparam int CW          = $clog2(2 * BYTE_CYCLES);

   localparam logic [CW-1:0] HALF   = CW'(BYTE_CYCLES);
   localparam logic [CW-1:0] LAST_N = CW'(BYTE_CYCLES - 1);
   localparam logic [CW-1:0] LAST_W = CW'(2 * BYTE_CYCLES - 1);

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q;
   logic                 wr_q;
   logic                 wide_q;
   logic [LOG2_NR-1:0]   idx_q;
   logic [W-1:0]         shift_q;
   logic [W-1:0]         rdata_q;
   logic [W-1:0]         result;
   logic                 accept;
   logic                 last;

   assign accept = req_valid && (state_q == ST_IDLE);
   assign last   = (cnt_q == (wide_q ? LAST_W : LAST_N));

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_valid) state_d = ST_SCAN;
         ST_SCAN: if (last)      state_d = ST_DONE;
         ST_DONE:                state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      req_ready = 1'b0;
      do_scan   = 1'b0;
      rsp_valid = 1'b0;
      bit_index = '0;
      reg_index = '0;
      scan_in   = '0;
      rsp_rdata = rdata_q;
      case (state_q)
         ST_IDLE: req_ready = 1'b1;
         ST_SCAN: begin
            do_scan   = 1'b1;
            bit_index = cnt_q;
            // Second half of a pair access targets the partner register.
            reg_index = (cnt_q < HALF) ? idx_q : (idx_q ^ LOG2_NR'(1));
            // Reads feed the register back to itself so it survives the scan.
            scan_in   = wr_q ? shift_q[NSHIFT-1:0] : scan_out;
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            rsp_rdata = result;
         end
         default: ;
      endcase
   end

   // ---------------- result selection ----------------
`ifdef REGFILE_SCAN_PORT_XCHG_EN
   // Old contents are collected separately so the outgoing write data never mixes in.
   logic [W-1:0] cap_q;
   logic [W-1:0] src;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                cap_q <= '0;
      else if (accept)             cap_q <= '0;
      else if (state_q == ST_SCAN) cap_q <= {scan_out, cap_q[W-1:NSHIFT]};
   end

   assign src    = wr_q ? cap_q : shift_q;
   assign result = wide_q ? src : {{REG_BITS{1'b0}}, src[W-1:REG_BITS]};
`else
   assign result = wr_q   ? '0 :
                   wide_q ? shift_q : {{REG_BITS{1'b0}}, shift_q[W-1:REG_BITS]};
`endif

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         wide_q  <= 1'b0;
         idx_q   <= '0;
         shift_q <= '0;
         rdata_q <= '0;
      end else if (accept) begin
         cnt_q   <= '0;
         wr_q    <= req_write;
         wide_q  <= req_wide;
         idx_q   <= req_index;
         shift_q <= !req_write ? '0 :
                    req_wide   ? req_wdata : {{REG_BITS{1'b0}}, req_wdata[REG_BITS-1:0]};
         rdata_q <= '0;
      end else if (state_q == ST_SCAN) begin
         // LSB-first capture: after a full pass the operand sits at the top.
         shift_q <= {scan_out, shift_q[W-1:NSHIFT]};
         if (!last) cnt_q <= cnt_q + CW'(1);
      end else if (state_q == ST_DONE) begin
         rdata_q <= result;
      end
   end

endmodule
